// File: rtl/moore_sched_pkg.sv
// Shared constants, FSM encoding and length clamp for the moore_machine scheduler.
// Pure declarations: no latency, no backpressure.
package moore_sched_pkg;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;
  localparam int STATE_W = 3;
  localparam int IDX_W   = $clog2(MAX_LEN);
  localparam logic [STATE_W-1:0] HIT_STATE = 3'd5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    FEED    = 2'd2,
    CAPTURE = 2'd3
  } sched_state_e;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester other than ptr wins.
// Combinational, zero latency; no backpressure (losers simply keep requesting).
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt_onehot
);

  always_comb begin
    gnt_onehot = 2'b00;
    case (req)
      2'b01:   gnt_onehot = 2'b01;
      2'b10:   gnt_onehot = 2'b10;
      2'b11:   gnt_onehot = ptr ? 2'b01 : 2'b10;
      default: gnt_onehot = 2'b00;
    endcase
  end

endmodule

// File: rtl/moore_seq_scheduler.sv
// Time-shares one moore_machine between two requesters; done arrives len+3 cycles after req.
// No backpressure: requests are sampled only in IDLE; optional hit counter under MOORE_SCHED_HIT_EN.
module moore_seq_scheduler
  import moore_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req,
  input  logic [LEN_W-1:0]   len0,
  input  logic [LEN_W-1:0]   len1,
  input  logic [MAX_LEN-1:0] pat0,
  input  logic [MAX_LEN-1:0] pat1,
  output logic [1:0]         gnt,
  output logic [1:0]         done,
  output logic [STATE_W-1:0] result,
  output logic               busy,
  output logic               fsm_rst_n,
  output logic               fsm_in,
  input  logic [STATE_W-1:0] fsm_state
`ifdef MOORE_SCHED_HIT_EN
  ,
  output logic [LEN_W-1:0]   hit_cnt
`endif
);

  sched_state_e       state_q, state_d;
  logic               ptr_q;
  logic [1:0]         win;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   idx_q;
  logic [MAX_LEN-1:0] pat_q;

  rr_arb2 u_arb (
    .req        (req),
    .ptr        (ptr_q),
    .gnt_onehot (win)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    busy      = (state_q != IDLE);
    fsm_rst_n = ~rst & (state_q != CLEAR);
    fsm_in    = 1'b0;
    case (state_q)
      IDLE:    if (req != 2'b00) state_d = CLEAR;
      CLEAR:   state_d = (len_q != '0) ? FEED : CAPTURE;
      FEED: begin
        fsm_in = pat_q[idx_q[IDX_W-1:0]];
        if (idx_q == len_q - LEN_W'(1)) state_d = CAPTURE;
      end
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Job latch, feed index and handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt    <= 2'b00;
      done   <= 2'b00;
      result <= '0;
      ptr_q  <= 1'b1;
      len_q  <= '0;
      idx_q  <= '0;
      pat_q  <= '0;
    end else begin
      done <= 2'b00;
      case (state_q)
        IDLE: if (req != 2'b00) begin
          gnt   <= win;
          pat_q <= win[0] ? pat0 : pat1;
          len_q <= clamp_len(win[0] ? len0 : len1);
        end
        CLEAR:   idx_q <= '0;
        FEED:    idx_q <= idx_q + LEN_W'(1);
        CAPTURE: begin
          result <= fsm_state;
          done   <= gnt;
          gnt    <= 2'b00;
          ptr_q  <= gnt[1];
        end
        default: ;
      endcase
    end
  end

`ifdef MOORE_SCHED_HIT_EN
  logic [LEN_W-1:0] hit_acc;
  logic             hit_now;

  assign hit_now = (fsm_state == HIT_STATE) && (hit_acc != '1);

  // The capture cycle's own hit is folded in as hit_cnt is loaded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_acc <= '0;
      hit_cnt <= '0;
    end else begin
      case (state_q)
        CLEAR:   hit_acc <= '0;
        FEED:    if (hit_now) hit_acc <= hit_acc + LEN_W'(1);
        CAPTURE: hit_cnt <= hit_now ? hit_acc + LEN_W'(1) : hit_acc;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_moore_seq_scheduler.sv
// Directed bench for moore_seq_scheduler with a behavioural shift-register moore_machine.
module tb_moore_seq_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [4:0]  len0, len1;
  logic [15:0] pat0, pat1;
  logic [1:0]  gnt, done;
  logic [2:0]  result;
  logic        busy, fsm_rst_n, fsm_in;
  logic [2:0]  m_state = 3'd0;
`ifdef MOORE_SCHED_HIT_EN
  logic [4:0]  hit_cnt;
`endif

  moore_seq_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .len0      (len0),
    .len1      (len1),
    .pat0      (pat0),
    .pat1      (pat1),
    .gnt       (gnt),
    .done      (done),
    .result    (result),
    .busy      (busy),
    .fsm_rst_n (fsm_rst_n),
    .fsm_in    (fsm_in),
    .fsm_state (m_state)
`ifdef MOORE_SCHED_HIT_EN
    ,
    .hit_cnt   (hit_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in moore_machine: state shifts in the serial bit
  always @(posedge clk or negedge fsm_rst_n) begin
    if (!fsm_rst_n) m_state <= 3'd0;
    else            m_state <= {m_state[1:0], fsm_in};
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [1:0] who;
    logic [2:0] res;
    int         at;
  } exp_t;
  exp_t sb[$];
  exp_t cur;
  int   tb_ptr = 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_len(input int l);
    return (l > 16) ? 16 : l;
  endfunction

  function automatic logic [2:0] model_state(input logic [15:0] p, input int l);
    logic [2:0] s;
    s = 3'd0;
    for (int k = 0; k < eff_len(l); k++) s = {s[1:0], p[k]};
    return s;
  endfunction

  function automatic int model_hits(input logic [15:0] p, input int l);
    logic [2:0] s;
    int h;
    s = 3'd0;
    h = 0;
    for (int k = 0; k < eff_len(l); k++) begin
      if (s == 3'd5) h++;
      s = {s[1:0], p[k]};
    end
    if (s == 3'd5) h++;
    return h;
  endfunction

  function automatic int winner(input logic [1:0] r);
    if (r == 2'b01) return 0;
    if (r == 2'b10) return 1;
    return (tb_ptr == 1) ? 0 : 1;
  endfunction

  task automatic push(input int w, input logic [15:0] p, input int l, input int at);
    exp_t e;
    e.who = (w == 0) ? 2'b01 : 2'b10;
    e.res = model_state(p, l);
    e.at  = at;
    sb.push_back(e);
    tb_ptr = w;
  endtask

  // Scoreboard: every done pulse must match the oldest expected job
  always @(negedge clk) begin
    if (!rst && done !== 2'b00) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'(done), 32'd0);
      end else begin
        cur = sb.pop_front();
        check("done_who", 32'(done), 32'(cur.who));
        check("result", 32'(result), 32'(cur.res));
        check("done_cycle", 32'(cyc), 32'(cur.at));
      end
    end
  end

  task automatic wait_done(input int max, input string tag);
    int n;
    n = 0;
    while (done === 2'b00 && n < max) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done != 2'b00), 32'd1);
  endtask

  task automatic wait_idle(input int max, input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < max) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  int c0, w1, w2, d1, gcnt;
  logic [15:0] p2;

  initial begin
    rst = 1'b1; req = 2'b00; len0 = '0; len1 = '0; pat0 = '0; pat1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fsm_rst_n", 32'(fsm_rst_n), 32'd0);
    check("rst_result", 32'(result), 32'd0);
`ifdef MOORE_SCHED_HIT_EN
    check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
`endif
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_fsm_rst_n", 32'(fsm_rst_n), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_gnt", 32'(gnt), 32'd0);
    check("idle_fsm_in", 32'(fsm_in), 32'd0);

    // Both requesting for two consecutive jobs
    len0 = 5'd3; pat0 = 16'h0006; len1 = 5'd2; pat1 = 16'h0001;
    @(posedge clk); #1;
    c0 = cyc; req = 2'b11;
    w1 = winner(2'b11);
    d1 = c0 + eff_len((w1 == 0) ? 3 : 2) + 3;
    push(w1, (w1 == 0) ? pat0 : pat1, (w1 == 0) ? 3 : 2, d1);
    w2 = winner(2'b11);
    push(w2, (w2 == 0) ? pat0 : pat1, (w2 == 0) ? 3 : 2, d1 + eff_len((w2 == 0) ? 3 : 2) + 3);
    @(negedge clk);
    @(negedge clk);
    check("arb_first_gnt", 32'(gnt), 32'd1 << w1);
    wait_done(40, "arb_first_done_timeout");
    @(negedge clk);
    check("arb_second_gnt", 32'(gnt), 32'd1 << w2);
    req = 2'b00;
    wait_idle(40, "arb_drain");

    // Single job of four bits, inputs disturbed after acceptance
    p2 = 16'h000B; len0 = 5'd4; pat0 = p2;
    @(posedge clk); #1;
    c0 = cyc; req = 2'b01;
    push(winner(2'b01), p2, 4, c0 + 7);
    gcnt = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (gnt == 2'b01) gcnt++;
      if (i == 1) begin
        check("clear_fsm_rst_n", 32'(fsm_rst_n), 32'd0);
        check("clear_busy", 32'(busy), 32'd1);
        check("clear_fsm_in", 32'(fsm_in), 32'd0);
        req = 2'b00; pat0 = 16'hFFFF; len0 = 5'd9;
      end
      if (i >= 2 && i <= 5) check($sformatf("feed_bit%0d", i - 2), 32'(fsm_in), 32'(p2[i-2]));
    end
    check("job4_gnt_cycles", 32'(gcnt), 32'd6);
    wait_idle(20, "job4_drain");
`ifdef MOORE_SCHED_HIT_EN
    check("job4_hit_cnt", 32'(hit_cnt), 32'(model_hits(p2, 4)));
`endif

    // Zero-length job
    len1 = 5'd0; pat1 = 16'h00FF;
    @(posedge clk); #1;
    c0 = cyc; req = 2'b10;
    push(winner(2'b10), pat1, 0, c0 + 3);
    @(negedge clk);
    @(negedge clk);
    req = 2'b00;
    @(negedge clk);
    check("len0_capture_gnt", 32'(gnt), 32'd2);
    check("len0_capture_fsm_in", 32'(fsm_in), 32'd0);
    wait_idle(20, "len0_drain");

    // Over-length job clamps to sixteen bits
    len0 = 5'd20; pat0 = 16'hA5C3;
    @(posedge clk); #1;
    c0 = cyc; req = 2'b01;
    push(winner(2'b01), pat0, 20, c0 + 19);
    gcnt = 0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (i == 1) req = 2'b00;
      if (gnt != 2'b00) gcnt++;
    end
    check("clamp_gnt_cycles", 32'(gcnt), 32'd18);
    wait_idle(20, "clamp_drain");
`ifdef MOORE_SCHED_HIT_EN
    check("clamp_hit_cnt", 32'(hit_cnt), 32'(model_hits(16'hA5C3, 20)));
`endif

    // Reset during FEED aborts the job
    len0 = 5'd8; pat0 = 16'h00B5;
    @(posedge clk); #1;
    req = 2'b01;
    for (int i = 0; i < 4; i++) @(negedge clk);
    req = 2'b00;
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    tb_ptr = 1;
    check("abort_gnt", 32'(gnt), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_fsm_rst_n", 32'(fsm_rst_n), 32'd0);
    check("abort_fsm_in", 32'(fsm_in), 32'd0);
    check("abort_result", 32'(result), 32'd0);
`ifdef MOORE_SCHED_HIT_EN
    check("abort_hit_cnt", 32'(hit_cnt), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_restart", 32'(busy), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
